// File: rtl/cmd_pkg.sv
// Shared types and constants for the oscilloscope command processor.
package cmd_pkg;

  typedef enum logic [7:0] {
    OP_DUMP     = 8'h01,
    OP_GAIN     = 8'h02,
    OP_TRIG_LVL = 8'h03,
    OP_DEC      = 8'h04,
    OP_TRIG_CFG = 8'h05
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE, SEND_RSP, WAIT_RSP, RD, RDW, SEND_SMP, WAIT_SMP
  } state_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  localparam logic [2:0] GAIN_RST     = 3'h2;
  localparam logic [7:0] TRIG_LVL_RST = 8'h80;
  localparam logic [5:0] TRIG_CFG_RST = 6'h00;
  localparam logic [3:0] DEC_RST      = 4'h0;

endpackage

// File: rtl/cmd_proc.sv
// Decodes UART commands: config writes answered with ACK/NAK, DUMP streams
// one channel's capture RAM out byte by byte. Sole driver of the UART tx side.
module cmd_proc
  import cmd_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_rdy,
  input  logic [23:0]       cmd,
  output logic              clr_cmd_rdy,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [1:0]        ram_ch,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_rdata,
  output logic [2:0]        gain1,
  output logic [2:0]        gain2,
  output logic [2:0]        gain3,
  output logic [7:0]        trig_lvl,
  output logic [5:0]        trig_cfg,
  output logic [3:0]        decimator
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t     state;
  opcode_t    op;
  logic [1:0] ch;
  logic       legal_dump, legal_wr;

  always_comb begin
    op         = opcode_t'(cmd[23:16]);
    ch         = cmd[9:8];
    legal_dump = (op == OP_DUMP) && (ch != 2'd0);
    legal_wr   = ((op == OP_GAIN) && (ch != 2'd0)) || (op == OP_TRIG_LVL) ||
                 (op == OP_DEC) || (op == OP_TRIG_CFG);
  end

  // trmt and ram_rd are raised on entry to SEND_*/RD so each is high for
  // exactly the cycle spent in that state; RDW then sees valid ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clr_cmd_rdy <= 1'b0;
      trmt        <= 1'b0;
      tx_data     <= 8'h00;
      ram_ch      <= 2'd1;
      ram_addr    <= '0;
      ram_rd      <= 1'b0;
      gain1       <= GAIN_RST;
      gain2       <= GAIN_RST;
      gain3       <= GAIN_RST;
      trig_lvl    <= TRIG_LVL_RST;
      trig_cfg    <= TRIG_CFG_RST;
      decimator   <= DEC_RST;
    end else begin
      clr_cmd_rdy <= 1'b0;
      trmt        <= 1'b0;
      ram_rd      <= 1'b0;
      unique case (state)
        IDLE: if (cmd_rdy) begin
          clr_cmd_rdy <= 1'b1;
          if (legal_dump) begin
            ram_ch   <= ch;
            ram_addr <= '0;
            ram_rd   <= 1'b1;
            state    <= RD;
          end else begin
            if (legal_wr) begin
              unique case (op)
                OP_GAIN: begin
                  if (ch == 2'd1) gain1 <= cmd[2:0];
                  if (ch == 2'd2) gain2 <= cmd[2:0];
                  if (ch == 2'd3) gain3 <= cmd[2:0];
                end
                OP_TRIG_LVL: trig_lvl  <= cmd[7:0];
                OP_DEC:      decimator <= cmd[3:0];
                OP_TRIG_CFG: trig_cfg  <= cmd[5:0];
                default: ;
              endcase
            end
            tx_data <= legal_wr ? ACK : NAK;
            trmt    <= 1'b1;
            state   <= SEND_RSP;
          end
        end
        SEND_RSP: state <= WAIT_RSP;
        // tx_done is still stale during the trmt cycle; only look at it here
        WAIT_RSP: if (tx_done) state <= IDLE;
        RD:       state <= RDW;
        RDW: begin
          tx_data <= ram_rdata;
          trmt    <= 1'b1;
          state   <= SEND_SMP;
        end
        SEND_SMP: state <= WAIT_SMP;
        WAIT_SMP: if (tx_done) begin
          if (ram_addr == LAST_ADDR) begin
            state <= IDLE;
          end else begin
            ram_addr <= ram_addr + 1'b1;
            ram_rd   <= 1'b1;
            state    <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc with UART and capture-RAM models (DEPTH = 4).
module tb_cmd_proc;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_rdy = 1'b0;
  logic [23:0]       cmd = '0;
  logic              clr_cmd_rdy, trmt, ram_rd;
  logic [7:0]        tx_data, trig_lvl;
  logic              tx_done = 1'b0;
  logic [1:0]        ram_ch;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata = '0;
  logic [2:0]        gain1, gain2, gain3;
  logic [5:0]        trig_cfg;
  logic [3:0]        decimator;

  int checks = 0;
  int errors = 0;

  cmd_proc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd),
    .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .ram_ch(ram_ch), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_rdata(ram_rdata),
    .gain1(gain1), .gain2(gain2), .gain3(gain3), .trig_lvl(trig_lvl),
    .trig_cfg(trig_cfg), .decimator(decimator)
  );

  always #5 clk = ~clk;

  // UART_comm receive side: commands queued by the test, held until cleared
  logic [23:0] cmd_q[$];
  int          clr_cnt = 0;
  always @(posedge clk) begin
    if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
      clr_cnt <= clr_cnt + 1;
    end else if (!cmd_rdy && cmd_q.size() > 0) begin
      cmd     <= cmd_q.pop_front();
      cmd_rdy <= 1'b1;
    end
  end

  // UART_comm transmit side: 6-cycle byte time, logs bytes and overlap violations
  logic [7:0] rx_q[$];
  int         trmt_cnt = 0;
  int         viol = 0;
  logic       busy = 1'b0;
  int         bcnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else if (trmt) begin
      if (busy) viol <= viol + 1;
      rx_q.push_back(tx_data);
      trmt_cnt <= trmt_cnt + 1;
      tx_done  <= 1'b0;
      busy     <= 1'b1;
      bcnt     <= 6;
    end else if (busy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        busy    <= 1'b0;
        tx_done <= 1'b1;
      end
    end
  end

  always @(posedge clk)
    if (ram_rd) ram_rdata <= 8'(ram_addr) ^ (8'(ram_ch) << 6);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 32'(rx_q.size() >= n), 32'd1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gain1", 32'(gain1), 32'h2);
    chk("rst_gain2", 32'(gain2), 32'h2);
    chk("rst_trig_lvl", 32'(trig_lvl), 32'h80);
    chk("rst_trig_cfg", 32'(trig_cfg), 32'h00);
    chk("rst_dec", 32'(decimator), 32'h0);
    chk("rst_outs", {trmt, clr_cmd_rdy, ram_rd, 1'b0, 2'(ram_ch), 2'(ram_addr), tx_data, 16'h0},
        {4'b0000, 2'd1, 2'd0, 8'h00, 16'h0});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: SET_GAIN ch2
    cmd_q.push_back(24'h020205);
    wait_bytes(1, "t1");
    chk("t1_gain2", 32'(gain2), 32'h5);
    chk("t1_gain13", {gain1, gain3}, {3'h2, 3'h2});
    chk("t1_rx", 32'(rx_q[0]), 32'hA5);
    chk("t1_nbytes", rx_q.size(), 1);
    chk("t1_clr", clr_cnt, 1);
    rx_q.delete();

    // 2: two writes back to back, ACKs in order
    cmd_q.push_back(24'h0300C4);
    cmd_q.push_back(24'h05002A);
    wait_bytes(2, "t2");
    chk("t2_trig_lvl", 32'(trig_lvl), 32'hC4);
    chk("t2_trig_cfg", 32'(trig_cfg), 32'h2A);
    chk("t2_rx", {rx_q[0], rx_q[1]}, {8'hA5, 8'hA5});
    chk("t2_nbytes", rx_q.size(), 2);
    rx_q.delete();

    // 3: illegal opcode and SET_GAIN ch0 -> NAK, nothing changes
    cmd_q.push_back(24'h070000);
    cmd_q.push_back(24'h020003);
    wait_bytes(2, "t3");
    chk("t3_rx", {rx_q[0], rx_q[1]}, {8'hEE, 8'hEE});
    chk("t3_regs", {gain1, gain2, gain3, trig_lvl, trig_cfg, decimator},
        {3'h2, 3'h5, 3'h2, 8'hC4, 6'h2A, 4'h0});
    chk("t3_clr", clr_cnt, 5);
    rx_q.delete();

    // 4: DUMP ch3, no trailing ACK
    trmt_cnt = 0;
    cmd_q.push_back(24'h010300);
    wait_bytes(4, "t4");
    chk("t4_rx", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 32'hC0C1C2C3);
    chk("t4_nbytes", rx_q.size(), 4);
    chk("t4_trmt_cnt", trmt_cnt, 4);
    chk("t4_ram_ch", 32'(ram_ch), 32'd3);
    rx_q.delete();

    // 5: SET_DEC queued behind a DUMP ch2
    cmd_q.push_back(24'h010200);
    cmd_q.push_back(24'h040007);
    wait_bytes(5, "t5");
    chk("t5_rx", {rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4]}, 40'h8081828384 & 40'hFFFFFFFF00 | 40'hA5);
    chk("t5_nbytes", rx_q.size(), 5);
    chk("t5_dec", 32'(decimator), 32'h7);
    rx_q.delete();

    // 6: reset after 2 of 4 dump bytes
    cmd_q.push_back(24'h010100);
    begin
      int k = 0;
      while (rx_q.size() < 2 && k < 3000) begin @(negedge clk); k++; end
      chk("t6_timeout", 32'(rx_q.size() >= 2), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_regs", {gain1, gain2, gain3, trig_lvl, trig_cfg, decimator},
        {3'h2, 3'h2, 3'h2, 8'h80, 6'h00, 4'h0});
    chk("t6_rst_outs", {trmt, clr_cmd_rdy, ram_rd, 1'b0, 2'(ram_ch), 2'(ram_addr), tx_data},
        {4'b0000, 2'd1, 2'd0, 8'h00});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    trmt_cnt = 0;
    repeat (40) @(negedge clk);
    chk("t6_no_trmt", trmt_cnt, 0);
    chk("t6_nbytes", rx_q.size(), 2);
    rx_q.delete();
    cmd_q.push_back(24'h030011);
    wait_bytes(1, "t6b");
    chk("t6_trig_lvl", 32'(trig_lvl), 32'h11);
    chk("t6_rx", 32'(rx_q[0]), 32'hA5);

    chk("no_overlap", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
